sr_display_receiver: RTL and testbench

- Deserializes the 74HC595-style display stream (serial data, shift clock, latch, output-enable) that the calculator's display driver produces.
- Captures one frame per latch pulse and decodes each 7-segment byte back to a symbol code.
- Presents the frame on a valid/ready handshake.
- Serves as the on-chip loopback checker and as the bench-side display model.
- Sits on the far end of uo_out[7:4].

---
 rtl/sr_display_receiver_if.sv | 33 +++
 rtl/sr_display_receiver.sv | 136 +++++++++++++
 tb/tb_sr_display_receiver.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sr_display_receiver_if.sv
// Bundle of the 74HC595-style display stream inputs and the decoded frame handshake
// seen by sr_display_receiver.
interface sr_display_if #(
  parameter int NUM_7_SEG_DISPLAYS = 5
);
  localparam int FRAME_BITS = NUM_7_SEG_DISPLAYS * 8;
  localparam int CODE_BITS  = NUM_7_SEG_DISPLAYS * 5;

  logic                  i_sr_data;
  logic                  i_sr_clk;
  logic                  i_sr_latch;
  logic                  i_sr_oe_n;
  logic [FRAME_BITS-1:0] o_frame;
  logic [CODE_BITS-1:0]  o_codes;
  logic [5:0]            o_bit_count;
  logic                  o_frame_error;
  logic                  o_frame_valid;
  logic                  i_frame_ready;
  logic                  o_frame_dropped;
  logic                  o_display_enabled;

  modport master (
    output i_sr_data, i_sr_clk, i_sr_latch, i_sr_oe_n, i_frame_ready,
    input  o_frame, o_codes, o_bit_count, o_frame_error, o_frame_valid,
           o_frame_dropped, o_display_enabled
  );

  modport slave (
    input  i_sr_data, i_sr_clk, i_sr_latch, i_sr_oe_n, i_frame_ready,
    output o_frame, o_codes, o_bit_count, o_frame_error, o_frame_valid,
           o_frame_dropped, o_display_enabled
  );
endinterface

// File: rtl/sr_display_receiver.sv
// Deserializes the chained shift-register display stream, latches one frame per latch
// pulse, decodes each 7-segment byte to a symbol code and offers it on valid/ready.
module sr_display_receiver #(
  parameter int NUM_7_SEG_DISPLAYS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_display_if.slave   bus
);
  localparam int FRAME_BITS = NUM_7_SEG_DISPLAYS * 8;
  localparam int CODE_BITS  = NUM_7_SEG_DISPLAYS * 5;

  // Segment bits {g,f,e,d,c,b,a}, active high; unknown patterns map to 31.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] code;
    case (seg)
      7'h3F:   code = 5'd0;
      7'h06:   code = 5'd1;
      7'h5B:   code = 5'd2;
      7'h4F:   code = 5'd3;
      7'h66:   code = 5'd4;
      7'h6D:   code = 5'd5;
      7'h7D:   code = 5'd6;
      7'h07:   code = 5'd7;
      7'h7F:   code = 5'd8;
      7'h6F:   code = 5'd9;
      7'h77:   code = 5'd10;
      7'h7C:   code = 5'd11;
      7'h39:   code = 5'd12;
      7'h5E:   code = 5'd13;
      7'h79:   code = 5'd14;
      7'h71:   code = 5'd15;
      7'h40:   code = 5'd16;
      7'h00:   code = 5'd17;
      7'h50:   code = 5'd18;
      default: code = 5'd31;
    endcase
    return code;
  endfunction

  logic                  sr_clk_q_r;
  logic                  sr_latch_q_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [5:0]            bit_cnt_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic [CODE_BITS-1:0]  codes_r;
  logic [5:0]            bit_count_r;
  logic                  valid_r;
  logic                  dropped_r;
  logic                  display_en_r;

  logic                  shift_rise_s;
  logic                  latch_rise_s;
  logic                  transfer_s;
  logic [FRAME_BITS-1:0] shift_next_s;
  logic [5:0]            cnt_next_s;
  logic [CODE_BITS-1:0]  codes_next_s;
  logic                  frame_error_s;

  assign shift_rise_s = bus.i_sr_clk & ~sr_clk_q_r;
  assign latch_rise_s = bus.i_sr_latch & ~sr_latch_q_r;
  assign transfer_s   = valid_r & bus.i_frame_ready;

  // Post-shift view, so a latch in the same cycle as a shift captures the new bit.
  always_comb begin
    shift_next_s = shift_r;
    cnt_next_s   = bit_cnt_r;
    if (shift_rise_s) begin
      shift_next_s = {shift_r[FRAME_BITS-2:0], bus.i_sr_data};
      if (bit_cnt_r != 6'd63) begin
        cnt_next_s = bit_cnt_r + 6'd1;
      end else begin
        cnt_next_s = bit_cnt_r;
      end
    end else begin
      shift_next_s = shift_r;
    end
    for (int k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
      codes_next_s[5*k +: 5] = decode_seg(shift_next_s[8*k +: 7]);
    end
  end

  // Error flag is derived from the already-registered count and codes.
  always_comb begin
    frame_error_s = (bit_count_r != 6'(FRAME_BITS));
    for (int k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
      if (codes_r[5*k +: 5] == 5'd31) begin
        frame_error_s = 1'b1;
      end else begin
        frame_error_s = frame_error_s;
      end
    end
  end

  // Edge history, shift/latch capture, handshake and display-enable registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_clk_q_r   <= 1'b0;
      sr_latch_q_r <= 1'b0;
      shift_r      <= '0;
      bit_cnt_r    <= 6'd0;
      frame_r      <= '0;
      codes_r      <= '0;
      bit_count_r  <= 6'd0;
      valid_r      <= 1'b0;
      dropped_r    <= 1'b0;
      display_en_r <= 1'b0;
    end else begin
      sr_clk_q_r   <= bus.i_sr_clk;
      sr_latch_q_r <= bus.i_sr_latch;
      shift_r      <= shift_next_s;
      display_en_r <= ~bus.i_sr_oe_n;
      if (latch_rise_s) begin
        frame_r     <= shift_next_s;
        codes_r     <= codes_next_s;
        bit_count_r <= cnt_next_s;
        bit_cnt_r   <= 6'd0;
        valid_r     <= 1'b1;
        dropped_r   <= valid_r & ~bus.i_frame_ready;
      end else begin
        bit_cnt_r <= cnt_next_s;
        valid_r   <= valid_r & ~transfer_s;
        dropped_r <= 1'b0;
      end
    end
  end

  assign bus.o_frame           = frame_r;
  assign bus.o_codes           = codes_r;
  assign bus.o_bit_count       = bit_count_r;
  assign bus.o_frame_error     = frame_error_s;
  assign bus.o_frame_valid     = valid_r;
  assign bus.o_frame_dropped   = dropped_r;
  assign bus.o_display_enabled = display_en_r;

endmodule

// File: tb/tb_sr_display_receiver.sv
// Directed bench for sr_display_receiver: drives the serial display stream and checks
// latched frames, decoded codes, handshake, overflow, boundary counts and reset.
module tb_sr_display_receiver;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  sr_display_if #(.NUM_7_SEG_DISPLAYS(5)) bus ();

  sr_display_receiver #(.NUM_7_SEG_DISPLAYS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends bits v[n-1] .. v[0], each held one clk high then one clk low on sr_clk.
  task automatic shift_bits(input logic [39:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.i_sr_data = v[i];
      bus.i_sr_clk  = 1'b1;
      tick();
      bus.i_sr_clk  = 1'b0;
      tick();
    end
  endtask

  task automatic latch_rise();
    bus.i_sr_latch = 1'b1;
    tick();
    bus.i_sr_latch = 1'b0;
  endtask

  task automatic consume(input string tag);
    bus.i_frame_ready = 1'b1;
    tick();
    bus.i_frame_ready = 1'b0;
    chk(tag, 64'(bus.o_frame_valid), 64'd0);
  endtask

  initial begin
    logic [39:0] g_frame;
    tests  = 0;
    failed = 0;
    rst_n             = 1'b0;
    bus.i_sr_data     = 1'b0;
    bus.i_sr_clk      = 1'b0;
    bus.i_sr_latch    = 1'b0;
    bus.i_sr_oe_n     = 1'b1;
    bus.i_frame_ready = 1'b0;
    tick();
    tick();
    chk("rst_frame",   64'(bus.o_frame), 64'd0);
    chk("rst_codes",   64'(bus.o_codes), 64'd0);
    chk("rst_count",   64'(bus.o_bit_count), 64'd0);
    chk("rst_valid",   64'(bus.o_frame_valid), 64'd0);
    chk("rst_dropped", 64'(bus.o_frame_dropped), 64'd0);
    chk("rst_disp",    64'(bus.o_display_enabled), 64'd0);
    chk("rst_error",   64'(bus.o_frame_error), 64'd1);
    rst_n = 1'b1;
    tick();

    // Frame A: blank,1,2,3,4
    shift_bits(40'h00065B4F66, 40);
    chk("a_pre_valid", 64'(bus.o_frame_valid), 64'd0);
    latch_rise();
    chk("a_frame", 64'(bus.o_frame), 64'h00065B4F66);
    chk("a_codes", 64'(bus.o_codes), 64'({5'd17, 5'd1, 5'd2, 5'd3, 5'd4}));
    chk("a_count", 64'(bus.o_bit_count), 64'd40);
    chk("a_error", 64'(bus.o_frame_error), 64'd0);
    chk("a_valid", 64'(bus.o_frame_valid), 64'd1);
    chk("a_dropped", 64'(bus.o_frame_dropped), 64'd0);
    tick();
    consume("a_consume");

    // Frame B held under back-pressure
    shift_bits(40'h403F3F3F07, 40);
    latch_rise();
    chk("b_codes", 64'(bus.o_codes), 64'({5'd16, 5'd0, 5'd0, 5'd0, 5'd7}));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_valid", 64'(bus.o_frame_valid), 64'd1);
      chk("b_hold_frame", 64'(bus.o_frame), 64'h403F3F3F07);
      chk("b_hold_drop",  64'(bus.o_frame_dropped), 64'd0);
    end
    consume("b_consume");
    tick();
    chk("b_idle_valid", 64'(bus.o_frame_valid), 64'd0);

    // Re-latch B, then overwrite with frame C without ready
    latch_rise();
    chk("c1_valid", 64'(bus.o_frame_valid), 64'd1);
    chk("c1_dropped", 64'(bus.o_frame_dropped), 64'd0);
    shift_bits(40'h7950500000, 40);
    latch_rise();
    chk("c_dropped", 64'(bus.o_frame_dropped), 64'd1);
    chk("c_valid", 64'(bus.o_frame_valid), 64'd1);
    chk("c_frame", 64'(bus.o_frame), 64'h7950500000);
    chk("c_codes", 64'(bus.o_codes), 64'({5'd14, 5'd18, 5'd18, 5'd17, 5'd17}));
    tick();
    chk("c_drop_pulse", 64'(bus.o_frame_dropped), 64'd0);
    chk("c_valid_hold", 64'(bus.o_frame_valid), 64'd1);
    consume("c_consume");

    // 39-bit frame: top bit is the leftover C[0]=0
    shift_bits(40'h00065B4F66, 39);
    latch_rise();
    chk("d_count", 64'(bus.o_bit_count), 64'd39);
    chk("d_error", 64'(bus.o_frame_error), 64'd1);
    chk("d_frame", 64'(bus.o_frame), 64'h00065B4F66);
    tick();
    consume("d_consume");

    // Unknown pattern 0x01 on display 3
    shift_bits(40'h0001000000, 40);
    latch_rise();
    chk("e_count", 64'(bus.o_bit_count), 64'd40);
    chk("e_codes", 64'(bus.o_codes), 64'({5'd17, 5'd31, 5'd17, 5'd17, 5'd17}));
    chk("e_error", 64'(bus.o_frame_error), 64'd1);
    tick();
    consume("e_consume");

    // 40th shift edge coincides with the latch edge
    g_frame = 40'h7F6F777C39;
    shift_bits(g_frame >> 1, 39);
    bus.i_sr_data  = g_frame[0];
    bus.i_sr_clk   = 1'b1;
    bus.i_sr_latch = 1'b1;
    tick();
    bus.i_sr_clk   = 1'b0;
    bus.i_sr_latch = 1'b0;
    chk("g_count", 64'(bus.o_bit_count), 64'd40);
    chk("g_frame", 64'(bus.o_frame), 64'h7F6F777C39);
    chk("g_codes", 64'(bus.o_codes), 64'({5'd8, 5'd9, 5'd10, 5'd11, 5'd12}));
    chk("g_error", 64'(bus.o_frame_error), 64'd0);
    tick();
    consume("g_consume");
    shift_bits(40'h1, 1);
    latch_rise();
    chk("g_next_count", 64'(bus.o_bit_count), 64'd1);
    chk("g_next_frame", 64'(bus.o_frame), 64'hFEDEEEF873);
    tick();
    consume("g_next_consume");

    // Reset in the middle of a frame
    shift_bits(40'hFFFFFFFFFF, 20);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_frame", 64'(bus.o_frame), 64'd0);
    chk("mid_rst_count", 64'(bus.o_bit_count), 64'd0);
    chk("mid_rst_valid", 64'(bus.o_frame_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    shift_bits(40'h6D7D000000, 40);
    latch_rise();
    chk("h_count", 64'(bus.o_bit_count), 64'd40);
    chk("h_frame", 64'(bus.o_frame), 64'h6D7D000000);
    chk("h_codes", 64'(bus.o_codes), 64'({5'd5, 5'd6, 5'd17, 5'd17, 5'd17}));
    chk("h_error", 64'(bus.o_frame_error), 64'd0);

    // Display enable follows ~oe_n one clk later
    bus.i_sr_oe_n = 1'b0;
    chk("oe_before", 64'(bus.o_display_enabled), 64'd0);
    tick();
    chk("oe_on", 64'(bus.o_display_enabled), 64'd1);
    bus.i_sr_oe_n = 1'b1;
    #1;
    chk("oe_hold", 64'(bus.o_display_enabled), 64'd1);
    tick();
    chk("oe_off", 64'(bus.o_display_enabled), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
